gf180mcu_fd_sc_mcu7t5v0__bufz_arb: RTL and testbench
====================================================

Name: gf180mcu_fd_sc_mcu7t5v0__bufz_arb

Overview:
Parametrised, registered, multi-channel tri-state bus driver. It is the successor to the single-bit bufz cell.
- NCH sources compete for one shared WIDTH-bit tri-state bus.
- A round-robin arbiter grants one source at a time and registers that source's data onto Z.
- Break-before-make turnaround cycles and an optional hold limit prevent bus contention and starvation.
- Sits between on-chip masters and a shared pad/bus segment.

Parameters:
WIDTH, 8, bus data width (>=1)
NCH, 4, number of requesting channels (2..16)
TURN, 1, extra dead cycles with OE=0 after each release (0..7)
HOLD_MAX, 0, max consecutive DRIVE cycles while others wait; 0 = unlimited

Ports:
CLK  input  1  clock, rising-edge
RN  input  1  asynchronous active-low reset
REQ  input  NCH  per-channel bus request, level-sensitive
I  input  NCH*WIDTH  channel data; channel k occupies I[k*WIDTH +: WIDTH]
GNT  output  NCH  one-hot grant, registered
OE  output  1  registered bus-drive enable (mirrors internal tri-state enable)
Z  output  WIDTH  tri-state bus; = DREG when OE=1, else all high-impedance
BUSY  output  1  high in DRIVE or TURN state

Behaviour:
- Clocking and reset: one clock CLK; reset RN is asynchronous, active-low.
- While RN=0:
  - state=IDLE, GNT=0, OE=0, BUSY=0, Z=all Z, DREG=0.
  - Round-robin pointer PTR=0, hold counter HC=0, turn counter TC=0.
  - RN falling mid-DRIVE releases Z immediately, with no clock required.
- States: IDLE, DRIVE, TURN.
- IDLE:
  - If REQ!=0 at an edge: winner W = first set REQ bit searching upward from PTR, modulo NCH.
  - Same edge: GNT<=onehot(W), OE<=1, DREG<=I[W], PTR<=(W+1) mod NCH, HC<=1, state<=DRIVE.
  - Latency: REQ sampled at edge n means GNT, OE and Z are valid after edge n.
- DRIVE (owner W):
  - Each edge with REQ[W]=1 and no preemption: DREG<=I[W], HC<=HC+1 (saturating).
  - Z therefore follows I[W] with 1-cycle latency.
  - Release condition: REQ[W]=0, or preemption (HOLD_MAX>0, HC>=HOLD_MAX, and any REQ[j]=1 with j!=W).
  - On release: GNT<=0, OE<=0, DREG held.
  - Next state: TC<=TURN and state<=TURN if TURN>0, else state<=IDLE.
- TURN:
  - TC decrements each edge; at TC==1 the next state is IDLE.
  - REQ is ignored for grant purposes in TURN.
- Break-before-make:
  - Between any two grants OE=0 for at least TURN+1 cycles, since IDLE itself consumes one edge.
  - GNT and OE never assert in the same cycle as a release.
- Simultaneous events:
  - Owner drops REQ while others assert: normal release; the next grant follows round-robin order.
  - Owner drops REQ in the same cycle preemption triggers: treated as a single release.
- Preempted owner: if it keeps REQ high, it re-queues at its round-robin position with no priority boost.
- HOLD_MAX=0: preemption is disabled. With HOLD_MAX>0 and no other requester, the owner keeps the bus indefinitely.
- Invariants:
  - GNT is always one-hot or zero.
  - OE == |GNT.
  - BUSY = (state!=IDLE).
- Out-of-range parameters are a compile-time error (generate-time check).

Test Plan:
- Reset: RN=0 with REQ=4'b1111 -> GNT=0, OE=0, Z=8'hzz, BUSY=0. Assert RN=0 mid-DRIVE -> Z goes to zz before the next CLK edge.
- Single grant, latency: REQ=4'b0100, I[2]=8'hA5 -> after the next edge GNT=4'b0100, Z=8'hA5. Change I[2] to 8'h3C -> Z=8'h3C one edge later.
- Turnaround (TURN=2): channel 0 releases while REQ[1]=1 -> OE=0 and Z=zz for exactly 3 cycles, then GNT=4'b0010.
- Round-robin: REQ=4'b1111 held, each owner releases after 1 cycle -> grant sequence 0,1,2,3,0; no channel granted twice before all others are served.
- Preemption (HOLD_MAX=3, TURN=0): channel 1 holds REQ, channel 3 requests -> channel 1 released after 3 DRIVE cycles, GNT=4'b1000 after the 1 IDLE cycle. With no competing requester, channel 1 keeps the grant for 20+ cycles.
- Invariant check (random REQ/I for 10k cycles, WIDTH=16, NCH=5) -> GNT is never multi-hot, OE==|GNT, and no cycle has an OE=1 edge directly between two different owners.

Source files
------------

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__bufz_arb.sv
// Registered multi-channel tri-state bus driver: round-robin arbitration of NCH
// sources onto one WIDTH-bit bus, with break-before-make turnaround and hold limit.
module gf180mcu_fd_sc_mcu7t5v0__bufz_arb #(
  parameter int WIDTH    = 8,
  parameter int NCH      = 4,
  parameter int TURN     = 1,
  parameter int HOLD_MAX = 0
) (
  input  logic                 CLK,
  input  logic                 RN,
  input  logic [NCH-1:0]       REQ,
  input  logic [NCH*WIDTH-1:0] I,
  output logic [NCH-1:0]       GNT,
  output logic                 OE,
  output wire  [WIDTH-1:0]     Z,
  output logic                 BUSY
);
  localparam int IW  = $clog2(NCH);
  localparam int HCW = $clog2(HOLD_MAX + 2);
  localparam int TCW = 3;

  if (WIDTH < 1 || NCH < 2 || NCH > 16 || TURN < 0 || TURN > 7 || HOLD_MAX < 0) begin : g_param_err
    $error("bufz_arb: parameter out of range");
  end

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_TURN} state_e;

  state_e                    state_q;
  logic [NCH-1:0]            gnt_q;
  logic                      oe_q;
  logic [WIDTH-1:0]          dreg_q;
  logic [IW-1:0]             ptr_q, own_q;
  logic [HCW-1:0]            hc_q;
  logic [TCW-1:0]            tc_q;
  logic [NCH-1:0][WIDTH-1:0] chan_d;
  logic [IW-1:0]             win;
  logic                      win_vld;
  logic                      others, preempt, rel;

  assign chan_d = I;

  // First requester at or above the pointer, wrapping modulo NCH.
  always_comb begin
    logic [IW:0] s;
    win_vld = 1'b0;
    win     = '0;
    s       = '0;
    for (int k = 0; k < NCH; k++) begin
      s = {1'b0, ptr_q} + (IW+1)'(k);
      if (s >= (IW+1)'(NCH)) s = s - (IW+1)'(NCH);
      if (!win_vld && REQ[s[IW-1:0]]) begin
        win_vld = 1'b1;
        win     = s[IW-1:0];
      end
    end
  end

  assign others  = |(REQ & ~gnt_q);
  assign preempt = (HOLD_MAX > 0) && (int'(hc_q) >= HOLD_MAX) && others;
  assign rel     = !REQ[own_q] || preempt;

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      oe_q    <= 1'b0;
      dreg_q  <= '0;
      ptr_q   <= '0;
      own_q   <= '0;
      hc_q    <= '0;
      tc_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (win_vld) begin
          state_q <= S_DRIVE;
          gnt_q   <= NCH'(1) << win;
          oe_q    <= 1'b1;
          dreg_q  <= chan_d[win];
          own_q   <= win;
          ptr_q   <= (win == IW'(NCH-1)) ? '0 : win + IW'(1);
          hc_q    <= HCW'(1);
        end
        S_DRIVE: if (rel) begin
          gnt_q <= '0;
          oe_q  <= 1'b0;
          if (TURN > 0) begin
            state_q <= S_TURN;
            tc_q    <= TCW'(TURN);
          end else begin
            state_q <= S_IDLE;
          end
        end else begin
          dreg_q <= chan_d[own_q];
          if (hc_q != '1) hc_q <= hc_q + HCW'(1);
        end
        S_TURN: begin
          tc_q <= tc_q - TCW'(1);
          if (tc_q == TCW'(1)) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign GNT  = gnt_q;
  assign OE   = oe_q;
  assign BUSY = (state_q != S_IDLE);
  // Async reset clears oe_q, so the bus is released without a clock edge.
  assign Z    = oe_q ? dreg_q : {WIDTH{1'bz}};
endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__bufz_arb.sv
// Bench for bufz_arb: three configurations checked every cycle against a
// behavioural arbiter model, plus directed literal checks.
module tb_gf180mcu_fd_sc_mcu7t5v0__bufz_arb;
  logic CLK = 1'b0;
  logic RN  = 1'b0;
  always #5 CLK = ~CLK;

  logic [3:0]  reqA = 4'hf, reqB = '0;
  logic [4:0]  reqC = '0;
  logic [31:0] dinA = '0, dinB = '0;
  logic [79:0] dinC = '0;
  logic [3:0]  gntA, gntB;
  logic [4:0]  gntC;
  logic        oeA, oeB, oeC, busyA, busyB, busyC;
  wire  [7:0]  zA, zB;
  wire  [15:0] zC;

  gf180mcu_fd_sc_mcu7t5v0__bufz_arb #(.WIDTH(8), .NCH(4), .TURN(2), .HOLD_MAX(0)) u_a (
    .CLK(CLK), .RN(RN), .REQ(reqA), .I(dinA), .GNT(gntA), .OE(oeA), .Z(zA), .BUSY(busyA));
  gf180mcu_fd_sc_mcu7t5v0__bufz_arb #(.WIDTH(8), .NCH(4), .TURN(0), .HOLD_MAX(3)) u_b (
    .CLK(CLK), .RN(RN), .REQ(reqB), .I(dinB), .GNT(gntB), .OE(oeB), .Z(zB), .BUSY(busyB));
  gf180mcu_fd_sc_mcu7t5v0__bufz_arb #(.WIDTH(16), .NCH(5), .TURN(1), .HOLD_MAX(2)) u_c (
    .CLK(CLK), .RN(RN), .REQ(reqC), .I(dinC), .GNT(gntC), .OE(oeC), .Z(zC), .BUSY(busyC));

  int npass = 0, ntot = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act !== exp) $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    else npass++;
  endtask

  // Model: phase 0 idle, 1 drive, 2 dead time; 'dead' counts remaining dead edges.
  typedef struct packed {
    int          phase;
    int          owner;
    int          ptr;
    int          held;
    int          dead;
    logic [15:0] dreg;
  } mdl_t;

  function automatic logic [15:0] chan(input logic [255:0] din, input int c, input int w);
    logic [255:0] t;
    logic [31:0]  m;
    t = din >> (c * w);
    m = (32'h1 << w) - 32'h1;
    return t[15:0] & m[15:0];
  endfunction

  function automatic mdl_t mstep(input mdl_t s, input int nch, input int turn, input int hold,
                                 input logic [15:0] req, input logic [255:0] din, input int w);
    mdl_t n;
    bit   oth;
    int   c;
    n = s;
    oth = 1'b0;
    if (s.phase == 0) begin
      for (int k = 0; k < nch; k++) begin
        c = (s.ptr + k) % nch;
        if (n.phase == 0 && req[4'(c)]) begin
          n.phase = 1; n.owner = c; n.ptr = (c + 1) % nch; n.held = 1;
          n.dreg  = chan(din, c, w);
        end
      end
    end else if (s.phase == 1) begin
      for (int j = 0; j < nch; j++) if (j != s.owner && req[4'(j)]) oth = 1'b1;
      if (!req[4'(s.owner)] || (hold > 0 && s.held >= hold && oth)) begin
        if (turn > 0) begin n.phase = 2; n.dead = turn; end
        else n.phase = 0;
      end else begin
        n.held = s.held + 1;
        n.dreg = chan(din, s.owner, w);
      end
    end else begin
      n.dead = s.dead - 1;
      if (n.dead == 0) n.phase = 0;
    end
    return n;
  endfunction

  mdl_t ma, mb, mc;
  always @(posedge CLK or negedge RN) begin
    if (!RN) begin
      ma <= '0; mb <= '0; mc <= '0;
    end else begin
      ma <= mstep(ma, 4, 2, 0, 16'(reqA), 256'(dinA), 8);
      mb <= mstep(mb, 4, 0, 3, 16'(reqB), 256'(dinB), 8);
      mc <= mstep(mc, 5, 1, 2, 16'(reqC), 256'(dinC), 16);
    end
  end

  task automatic cmp(input string tag, input mdl_t m, input logic [15:0] gnt, input logic oe,
                     input logic busy, input logic [15:0] z, input logic [15:0] zm,
                     input logic [15:0] pg);
    logic [15:0] eg;
    eg = (m.phase == 1) ? (16'h1 << m.owner) : 16'h0;
    chk({tag, "_gnt"}, 32'(gnt), 32'(eg));
    chk({tag, "_oe"}, 32'(oe), 32'(m.phase == 1));
    chk({tag, "_busy"}, 32'(busy), 32'(m.phase != 0));
    if (m.phase == 1) chk({tag, "_z"}, 32'(z & zm), 32'(m.dreg & zm));
    chk({tag, "_onehot"}, 32'($onehot0(gnt)), 32'd1);
    chk({tag, "_oe_gnt"}, 32'(oe), 32'(|gnt));
    if (pg != 0 && gnt != 0) chk({tag, "_bbm"}, 32'(gnt), 32'(pg));
  endtask

  logic [15:0] pgA = '0, pgB = '0, pgC = '0;
  always @(negedge CLK) begin
    cmp("A", ma, 16'(gntA), oeA, busyA, 16'(zA), 16'h00ff, pgA);
    cmp("B", mb, 16'(gntB), oeB, busyB, 16'(zB), 16'h00ff, pgB);
    cmp("C", mc, 16'(gntC), oeC, busyC, zC, 16'hffff, pgC);
    pgA <= 16'(gntA);
    pgB <= 16'(gntB);
    pgC <= 16'(gntC);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  int rr_exp[5] = '{0, 1, 2, 3, 0};

  initial begin
    // Reset with all requests asserted.
    step(2);
    chk("rst_gnt", 32'(gntA), 32'h0);
    chk("rst_oe", 32'(oeA), 32'h0);
    chk("rst_busy", 32'(busyA), 32'h0);
    reqA = '0;
    RN   = 1'b1;
    step(1);

    // Round-robin with every channel requesting.
    reqA = 4'hf;
    for (int g = 0; g < 5; g++) begin
      int b;
      b = 0;
      while (gntA == 0 && b < 10) begin step(1); b++; end
      chk("rr_gnt", 32'(gntA), 32'h1 << rr_exp[g]);
      reqA = 4'hf & ~gntA;
      step(1);
      reqA = (g == 4) ? 4'h0 : 4'hf;
    end
    step(3);

    // Single grant and data latency.
    dinA[23:16] = 8'hA5;
    reqA = 4'b0100;
    step(1);
    chk("sg_gnt", 32'(gntA), 32'h4);
    chk("sg_oe", 32'(oeA), 32'h1);
    chk("sg_z", 32'(zA), 32'hA5);
    dinA[23:16] = 8'h3C;
    #1 chk("sg_z_hold", 32'(zA), 32'hA5);
    step(1);
    chk("sg_z_follow", 32'(zA), 32'h3C);
    reqA = '0;
    step(1);
    chk("rel_oe", 32'(oeA), 32'h0);
    chk("rel_busy", 32'(busyA), 32'h1);
    step(2);
    chk("turn_done", 32'(busyA), 32'h0);

    // Turnaround: channel 0 hands over to channel 1.
    dinA[7:0]  = 8'h11;
    dinA[15:8] = 8'h22;
    reqA = 4'b0001;
    step(1);
    chk("ta_gnt0", 32'(gntA), 32'h1);
    reqA = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      step(1);
      chk("ta_dead_oe", 32'(oeA), 32'h0);
    end
    step(1);
    chk("ta_gnt1", 32'(gntA), 32'h2);
    chk("ta_z", 32'(zA), 32'h22);

    // Reset mid-drive releases the bus without a clock.
    @(negedge CLK);
    #1 RN = 1'b0;
    #1;
    chk("mrst_oe", 32'(oeA), 32'h0);
    chk("mrst_gnt", 32'(gntA), 32'h0);
    chk("mrst_busy", 32'(busyA), 32'h0);
    @(posedge CLK);
    #1;
    reqA = '0;
    RN   = 1'b1;
    step(1);

    // Preemption with HOLD_MAX=3, TURN=0.
    dinB[15:8]  = 8'h5A;
    dinB[31:24] = 8'hC3;
    reqB = 4'b0010;
    step(1);
    chk("pe_gnt1", 32'(gntB), 32'h2);
    reqB = 4'b1010;
    step(1);
    chk("pe_hold2", 32'(gntB), 32'h2);
    step(1);
    chk("pe_hold3", 32'(gntB), 32'h2);
    step(1);
    chk("pe_rel", 32'(oeB), 32'h0);
    step(1);
    chk("pe_gnt3", 32'(gntB), 32'h8);
    chk("pe_z", 32'(zB), 32'hC3);
    reqB = 4'b0010;
    step(1);
    chk("pe_rel3", 32'(oeB), 32'h0);
    step(1);
    chk("pe_regnt1", 32'(gntB), 32'h2);
    for (int k = 0; k < 22; k++) begin
      step(1);
      chk("hold_keep", 32'(gntB), 32'h2);
    end
    reqB = '0;
    step(2);

    // Random traffic on the 5-channel, 16-bit instance.
    for (int n = 0; n < 10000; n++) begin
      for (int k = 0; k < 5; k++) begin
        reqC[k] = ($urandom_range(0, 99) < 70);
        dinC[k*16 +: 16] = 16'($urandom);
      end
      step(1);
    end
    reqC = '0;
    step(4);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
